// File: rtl/fir_poly_pkg.sv
// Shared FSM encoding and width helpers for the polyphase interpolator.
// Rounding is selected by FIR_INTERP_POLY_ROUND_EN (see fir_interp_mac).
package fir_poly_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_N_TAPS = 120;
    localparam int DEF_L      = 20;
    localparam int DEF_K      = 6;
    localparam int TAP_ADDR_W = cw(DEF_N_TAPS);
    localparam int PHASE_W    = cw(DEF_L);
    localparam int TAPIDX_W   = cw(DEF_K);

endpackage

// File: rtl/fir_interp_mac.sv
// Multiply-accumulate and output scale/saturate for one polyphase branch.
// FIR_INTERP_POLY_ROUND_EN selects round-half-up instead of floor.
module fir_interp_mac
    import fir_poly_pkg::*;
#(
    parameter int INPUT_WIDTH  = 12,
    parameter int TAP_WIDTH    = 16,
    parameter int ACC_WIDTH    = 35,
    parameter int OUTPUT_WIDTH = 16,
    parameter int OUT_SHIFT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           first,
    input  logic signed [INPUT_WIDTH-1:0]  x,
    input  logic signed [TAP_WIDTH-1:0]    tap,
    output logic signed [OUTPUT_WIDTH-1:0] y
);

    localparam int PW = INPUT_WIDTH + TAP_WIDTH;
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] MAXV =
        EW'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] MINV =
        EW'(-(64'sd1 <<< (OUTPUT_WIDTH - 1)));

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [EW-1:0]        biased;
    logic signed [EW-1:0]        shifted;

    assign prod     = x * tap;
    assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
    assign sum      = first ? prod_ext : acc + prod_ext;

    // One guard bit keeps the rounding bias from wrapping the accumulator.
`ifdef FIR_INTERP_POLY_ROUND_EN
    generate
        if (OUT_SHIFT > 0) begin : g_round
            assign biased = $signed({sum[ACC_WIDTH-1], sum})
                          + (EW'(1) <<< (OUT_SHIFT - 1));
        end else begin : g_trunc
            assign biased = $signed({sum[ACC_WIDTH-1], sum});
        end
    endgenerate
`else
    assign biased = $signed({sum[ACC_WIDTH-1], sum});
`endif

    assign shifted = biased >>> OUT_SHIFT;

    always_comb begin
        y = OUTPUT_WIDTH'(shifted);
        if (shifted > MAXV) begin
            y = MAXV[OUTPUT_WIDTH-1:0];
        end else if (shifted < MINV) begin
            y = MINV[OUTPUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/fir_interp_poly.sv
// Polyphase FIR interpolator: one input sample yields L outputs, K MACs each.
// Output rounding mode follows FIR_INTERP_POLY_ROUND_EN.
module fir_interp_poly
    import fir_poly_pkg::*;
#(
    parameter int N_TAPS       = 120,
    parameter int L            = 20,
    parameter int K            = 6,
    parameter int INPUT_WIDTH  = 12,
    parameter int TAP_WIDTH    = 16,
    parameter int ACC_WIDTH    = 35,
    parameter int OUTPUT_WIDTH = 16,
    parameter int OUT_SHIFT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    input  logic                           din_valid,
    output logic                           din_ready,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic [cw(N_TAPS)-1:0]          tap_addr,
    input  logic signed [TAP_WIDTH-1:0]    tap
);

    localparam int AW  = cw(N_TAPS);
    localparam int JW  = cw(K);
    localparam int PHW = cw(L);

    state_t                          state;
    logic signed [INPUT_WIDTH-1:0]   x [K];
    logic [PHW-1:0]                  p;
    logic [JW-1:0]                   j;
    logic signed [OUTPUT_WIDTH-1:0]  scaled;
    logic                            last_tap;

    assign last_tap = (j == JW'(K - 1));

    fir_interp_mac #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .TAP_WIDTH   (TAP_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .OUT_SHIFT   (OUT_SHIFT)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .en   (state == MAC),
        .first(j == '0),
        .x    (x[j]),
        .tap  (tap),
        .y    (scaled)
    );

    // tap_addr tracks j*L + p incrementally instead of multiplying.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            for (int i = 0; i < K; i++) x[i] <= '0;
            p          <= '0;
            j          <= '0;
            tap_addr   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            din_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    din_ready <= 1'b1;
                    if (din_valid && din_ready) begin
                        x[0] <= din;
                        for (int i = 1; i < K; i++) x[i] <= x[i-1];
                        p         <= '0;
                        j         <= '0;
                        tap_addr  <= '0;
                        din_ready <= 1'b0;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        dout       <= scaled;
                        dout_valid <= 1'b1;
                        state      <= OUT;
                    end else begin
                        j        <= j + JW'(1);
                        tap_addr <= tap_addr + AW'(L);
                    end
                end
                OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        if (p == PHW'(L - 1)) begin
                            tap_addr  <= '0;
                            din_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            p        <= p + PHW'(1);
                            j        <= '0;
                            tap_addr <= AW'(p) + AW'(1);
                            state    <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp_poly.sv
// Scoreboard bench for fir_interp_poly: impulse, timing, back-pressure,
// saturation, mid-frame reset and output rounding (second instance).
module tb_fir_interp_poly;

    localparam int NT = 8;
    localparam int LL = 4;
    localparam int KK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic signed [11:0] din;
    logic               din_valid;
    logic               din_ready;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [2:0]         tap_addr;
    logic signed [15:0] tap;
    logic signed [15:0] h [NT];

    logic signed [11:0] r_din;
    logic               r_din_valid;
    logic               r_din_ready;
    logic signed [15:0] r_dout;
    logic               r_dout_valid;
    logic               r_dout_ready;
    logic [2:0]         r_tap_addr;
    logic signed [15:0] r_tap;
    logic signed [15:0] hr [NT];

    assign tap   = h[tap_addr];
    assign r_tap = hr[r_tap_addr];

    fir_interp_poly #(
        .N_TAPS(NT), .L(LL), .K(KK), .INPUT_WIDTH(12), .TAP_WIDTH(16),
        .ACC_WIDTH(35), .OUTPUT_WIDTH(16), .OUT_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .tap_addr(tap_addr), .tap(tap)
    );

    fir_interp_poly #(
        .N_TAPS(NT), .L(LL), .K(KK), .INPUT_WIDTH(12), .TAP_WIDTH(16),
        .ACC_WIDTH(35), .OUTPUT_WIDTH(16), .OUT_SHIFT(1)
    ) dut_rnd (
        .clk(clk), .rst(rst), .din(r_din), .din_valid(r_din_valid),
        .din_ready(r_din_ready), .dout(r_dout), .dout_valid(r_dout_valid),
        .dout_ready(r_dout_ready), .tap_addr(r_tap_addr), .tap(r_tap)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_out  = 0;

    longint q[$];
    longint rq[$];
    int     acc_times[$];
    int     out_times[$];
    longint xm [KK];
    longint xr [KK];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint scale(input longint s, input int sh);
        longint v;
        v = s;
`ifdef FIR_INTERP_POLY_ROUND_EN
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
`endif
        v = v >>> sh;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic void push_model(input int sel, input int s);
        longint acc;
        if (sel == 0) begin
            for (int i = KK - 1; i > 0; i--) xm[i] = xm[i-1];
            xm[0] = s;
            for (int ph = 0; ph < LL; ph++) begin
                acc = 0;
                for (int t = 0; t < KK; t++)
                    acc += longint'(h[t*LL+ph]) * xm[t];
                q.push_back(scale(acc, 0));
            end
        end else begin
            for (int i = KK - 1; i > 0; i--) xr[i] = xr[i-1];
            xr[0] = s;
            for (int ph = 0; ph < LL; ph++) begin
                acc = 0;
                for (int t = 0; t < KK; t++)
                    acc += longint'(hr[t*LL+ph]) * xr[t];
                rq.push_back(scale(acc, 1));
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", dout_valid, 0);
            end else begin
                check("dout", dout, q.pop_front());
                out_times.push_back(cyc + 1);
                n_out++;
            end
        end
        if (!rst && r_dout_valid && r_dout_ready) begin
            if (rq.size() == 0) begin
                check("spurious_rnd_out", r_dout_valid, 0);
            end else begin
                check("rnd_dout", r_dout, rq.pop_front());
            end
        end
    end

    task automatic send(input int sel, input int s);
        bit ok;
        ok = 1'b0;
        if (sel == 0) begin
            din = 12'(s);
            din_valid = 1'b1;
        end else begin
            r_din = 12'(s);
            r_din_valid = 1'b1;
        end
        push_model(sel, s);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ((sel == 0) ? din_ready : r_din_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", ok, 1);
        @(posedge clk);
        #1;
        if (sel == 0) acc_times.push_back(cyc);
    endtask

    task automatic drain();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (q.size() == 0 && rq.size() == 0 && din_ready && r_din_ready)
                break;
        end
        check("drain", q.size() + rq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < NT; i++) h[i] = 16'(i + 1);
    endtask

    int base;
    int t0;
    bit hit;

    initial begin
        din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        r_din = '0; r_din_valid = 1'b0; r_dout_ready = 1'b1;
        set_ramp();
        for (int i = 0; i < NT; i++) hr[i] = (i == 0) ? 16'sd1 : 16'sd0;
        for (int i = 0; i < KK; i++) begin xm[i] = 0; xr[i] = 0; end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_dout", dout, 0);
        check("rst_tap_addr", tap_addr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", din_ready, 1);

        // impulse and timing under continuous valid
        acc_times.delete();
        out_times.delete();
        send(0, 1);
        send(0, 0);
        send(0, 0);
        din_valid = 1'b0;
        drain();
        t0 = acc_times[0];
        for (int i = 0; i < 4; i++)
            check("out_latency", out_times[i] - t0, 3 * (i + 1));
        check("in_period", acc_times[1] - acc_times[0], 13);

        // back-pressure at phase 1
        base = n_out;
        send(0, 1);
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (dout_valid && n_out == base + 1) begin
                hit = 1'b1;
                break;
            end
        end
        check("bp_reach_phase1", hit, 1);
        dout_ready = 1'b0;
        din = 12'sd7;
        din_valid = 1'b1;
        check("bp_expect", q[0], 2);
        repeat (10) begin
            @(negedge clk);
            check("bp_dout", dout, q[0]);
            check("bp_valid", dout_valid, 1);
            check("bp_addr", tap_addr, (KK - 1) * LL + 1);
            check("bp_din_ready", din_ready, 0);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        drain();

        // saturation
        for (int i = 0; i < NT; i++) h[i] = 16'sh7FFF;
        send(0, 2047);
        send(0, 2047);
        send(0, -2048);
        send(0, -2048);
        din_valid = 1'b0;
        drain();

        // reset during phase 2 MAC
        set_ramp();
        base = n_out;
        send(0, 1);
        din_valid = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (n_out == base + 2 && !dout_valid) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_reach_phase2", hit, 1);
        rst = 1'b1;
        #1;
        check("midrst_dout_valid", dout_valid, 0);
        check("midrst_din_ready", din_ready, 0);
        q.delete();
        rq.delete();
        for (int i = 0; i < KK; i++) begin xm[i] = 0; xr[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready_after", din_ready, 1);
        base = n_out;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_output", n_out, base);
        send(0, 1);
        send(0, 0);
        send(0, 0);
        din_valid = 1'b0;
        drain();

        // rounding instance (OUT_SHIFT = 1)
        send(1, 1);
        send(1, -1);
        r_din_valid = 1'b0;
        drain();

        check("sb_empty", q.size() + rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
